// File: rtl/exmem_skid_stage_pkg.sv
// Shared types and constants for the EX->MEM pipeline stage.
// Control-bit indices, default widths and the stage occupancy state.
package mips_pipe_pkg;

  localparam int unsigned CTRL_REGWRITE = 0;
  localparam int unsigned CTRL_MEMTORG  = 1;
  localparam int unsigned CTRL_MEMWRITE = 2;

  localparam int unsigned CTRL_W         = 3;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_REG_ADDR_W = 5;
  localparam int unsigned OCC_W          = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  // Number of entries held in a given state.
  function automatic logic [OCC_W-1:0] state_occ(input stage_state_t s);
    logic [OCC_W-1:0] occ;
    occ = '0;
    case (s)
      EMPTY:   occ = OCC_W'(0);
      ONE:     occ = OCC_W'(1);
      FULL:    occ = OCC_W'(2);
      default: occ = OCC_W'(0);
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/exmem_skid_stage_if.sv
// EX-side and MEM-side handshake/payload bundle of the EX->MEM stage.
// slave = the stage itself, master = the surrounding pipeline.
interface exmem_skid_stage_if
  import mips_pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned CTRL_W     = mips_pipe_pkg::CTRL_W
);

  logic                  in_valid;
  logic                  in_ready;
  logic [CTRL_W-1:0]     CtrlE;
  logic [REG_ADDR_W-1:0] WriteRegE;
  logic [DATA_W-1:0]     WriteDataE;
  logic [DATA_W-1:0]     ALUOutE;

  logic                  out_valid;
  logic                  out_ready;
  logic [CTRL_W-1:0]     CtrlM;
  logic [REG_ADDR_W-1:0] WriteRegM;
  logic [DATA_W-1:0]     WriteDataM;
  logic [DATA_W-1:0]     ALUOutM;

  logic [OCC_W-1:0]      occupancy;

  modport master (
    output in_valid, CtrlE, WriteRegE, WriteDataE, ALUOutE, out_ready,
    input  in_ready, out_valid, CtrlM, WriteRegM, WriteDataM, ALUOutM, occupancy
  );

  modport slave (
    input  in_valid, CtrlE, WriteRegE, WriteDataE, ALUOutE, out_ready,
    output in_ready, out_valid, CtrlM, WriteRegM, WriteDataM, ALUOutM, occupancy
  );

endinterface

// File: rtl/exmem_skid_stage_entry.sv
// One payload slot of the EX->MEM stage: load-enabled data with a
// synchronous control clear (bubble insertion) and async reset.
module pipe_entry #(
  parameter int unsigned CTRL_W     = 3,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  clr_ctrl,
  input  logic [CTRL_W-1:0]     d_ctrl,
  input  logic [REG_ADDR_W-1:0] d_reg,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W-1:0]     d_alu,
  output logic [CTRL_W-1:0]     q_ctrl,
  output logic [REG_ADDR_W-1:0] q_reg,
  output logic [DATA_W-1:0]     q_wdata,
  output logic [DATA_W-1:0]     q_alu
);

  // Clearing control wins over a load so a flushed slot is always a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_ctrl <= '0;
    end else if (clr_ctrl) begin
      q_ctrl <= '0;
    end else if (load) begin
      q_ctrl <= d_ctrl;
    end
  end

  // Data fields are only updated on load; they hold across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg   <= '0;
      q_wdata <= '0;
      q_alu   <= '0;
    end else if (load) begin
      q_reg   <= d_reg;
      q_wdata <= d_wdata;
      q_alu   <= d_alu;
    end
  end

endmodule

// File: rtl/exmem_skid_stage.sv
// EX->MEM pipeline register with valid/ready handshake and a 2-entry skid
// buffer; in_ready is a pure state decode so MEM back-pressure is registered.
module exmem_skid_stage #(
  parameter int unsigned DATA_W     = mips_pipe_pkg::DEF_DATA_W,
  parameter int unsigned REG_ADDR_W = mips_pipe_pkg::DEF_REG_ADDR_W,
  parameter int unsigned CTRL_W     = mips_pipe_pkg::CTRL_W
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                FlushM,
  exmem_skid_stage_if.slave   bus
);

  import mips_pipe_pkg::*;

  stage_state_t state, state_n;

  logic acc, dep;
  logic main_load, main_sel_skid, main_clr;
  logic skid_load, skid_clr;

  logic [CTRL_W-1:0]     main_d_ctrl, main_q_ctrl, skid_q_ctrl;
  logic [REG_ADDR_W-1:0] main_d_reg,  main_q_reg,  skid_q_reg;
  logic [DATA_W-1:0]     main_d_wdata, main_q_wdata, skid_q_wdata;
  logic [DATA_W-1:0]     main_d_alu,  main_q_alu,  skid_q_alu;

  // Handshake flags decode straight from the state register.
  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign bus.occupancy = state_occ(state);

  assign acc = bus.in_valid  & bus.in_ready;
  assign dep = bus.out_valid & bus.out_ready;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state <= EMPTY;
    end else begin
      state <= state_n;
    end
  end

  // Next state and slot controls; flush overrides every transfer.
  always_comb begin
    state_n       = state;
    main_load     = 1'b0;
    main_sel_skid = 1'b0;
    main_clr      = 1'b0;
    skid_load     = 1'b0;
    skid_clr      = 1'b0;

    if (FlushM) begin
      state_n  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            state_n   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (acc && !dep) begin
            state_n   = FULL;
            skid_load = 1'b1;
          end else if (dep && !acc) begin
            state_n  = EMPTY;
            main_clr = 1'b1;
          end else if (acc && dep) begin
            state_n   = ONE;
            main_load = 1'b1;
          end
        end
        FULL: begin
          if (dep) begin
            state_n       = ONE;
            main_load     = 1'b1;
            main_sel_skid = 1'b1;
          end
        end
        default: begin
          state_n  = EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  // Main slot refills from the older skid entry when draining FULL.
  always_comb begin
    main_d_ctrl  = bus.CtrlE;
    main_d_reg   = bus.WriteRegE;
    main_d_wdata = bus.WriteDataE;
    main_d_alu   = bus.ALUOutE;
    if (main_sel_skid) begin
      main_d_ctrl  = skid_q_ctrl;
      main_d_reg   = skid_q_reg;
      main_d_wdata = skid_q_wdata;
      main_d_alu   = skid_q_alu;
    end
  end

  pipe_entry #(
    .CTRL_W     (CTRL_W),
    .REG_ADDR_W (REG_ADDR_W),
    .DATA_W     (DATA_W)
  ) u_main (
    .clk      (CLK),
    .rst_n    (Reset),
    .load     (main_load),
    .clr_ctrl (main_clr),
    .d_ctrl   (main_d_ctrl),
    .d_reg    (main_d_reg),
    .d_wdata  (main_d_wdata),
    .d_alu    (main_d_alu),
    .q_ctrl   (main_q_ctrl),
    .q_reg    (main_q_reg),
    .q_wdata  (main_q_wdata),
    .q_alu    (main_q_alu)
  );

  pipe_entry #(
    .CTRL_W     (CTRL_W),
    .REG_ADDR_W (REG_ADDR_W),
    .DATA_W     (DATA_W)
  ) u_skid (
    .clk      (CLK),
    .rst_n    (Reset),
    .load     (skid_load),
    .clr_ctrl (skid_clr),
    .d_ctrl   (bus.CtrlE),
    .d_reg    (bus.WriteRegE),
    .d_wdata  (bus.WriteDataE),
    .d_alu    (bus.ALUOutE),
    .q_ctrl   (skid_q_ctrl),
    .q_reg    (skid_q_reg),
    .q_wdata  (skid_q_wdata),
    .q_alu    (skid_q_alu)
  );

  assign bus.CtrlM      = main_q_ctrl;
  assign bus.WriteRegM  = main_q_reg;
  assign bus.WriteDataM = main_q_wdata;
  assign bus.ALUOutM    = main_q_alu;

endmodule

// File: tb/tb_exmem_skid_stage.sv
// Scoreboard bench for exmem_skid_stage: directed vectors plus a random
// valid/ready phase; a negedge monitor checks every transfer against a queue.
module tb_exmem_skid_stage;

  import mips_pipe_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 3;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [RW-1:0] wreg;
    logic [DW-1:0] wdata;
    logic [DW-1:0] alu;
  } entry_t;

  logic CLK = 1'b0;
  logic Reset;
  logic FlushM;

  exmem_skid_stage_if #(.DATA_W(DW), .REG_ADDR_W(RW), .CTRL_W(CW)) bus ();

  exmem_skid_stage #(.DATA_W(DW), .REG_ADDR_W(RW), .CTRL_W(CW)) dut (
    .CLK    (CLK),
    .Reset  (Reset),
    .FlushM (FlushM),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  int          n_chk = 0;
  int          n_fail = 0;
  entry_t      sb[$];
  int unsigned model_occ = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [CW-1:0] c, input logic [RW-1:0] r,
                       input logic [DW-1:0] wd, input logic [DW-1:0] a, input bit ordy);
    bus.in_valid   = v;
    bus.CtrlE      = c;
    bus.WriteRegE  = r;
    bus.WriteDataE = wd;
    bus.ALUOutE    = a;
    bus.out_ready  = ordy;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Monitor: flags vs occupancy model, then pop on departure, push on accept.
  always @(negedge CLK) begin
    entry_t e;
    bit     acc_m, dep_m;
    if (!Reset) begin
      model_occ = 0;
      sb.delete();
    end else begin
      chk("occupancy", 32'(bus.occupancy), model_occ);
      chk("in_ready",  32'(bus.in_ready),  32'(model_occ != 2));
      chk("out_valid", 32'(bus.out_valid), 32'(model_occ != 0));
      if (!bus.out_valid) chk("bubble_ctrl", 32'(bus.CtrlM), 32'(0));
      acc_m = bus.in_valid && (model_occ != 2);
      dep_m = (model_occ != 0) && bus.out_ready;
      if (dep_m) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output actual=%h required=none at %0t", bus.ALUOutM, $time);
        end else begin
          e = sb.pop_front();
          chk("sb_alu",   bus.ALUOutM,           e.alu);
          chk("sb_wdata", bus.WriteDataM,        e.wdata);
          chk("sb_reg",   32'(bus.WriteRegM),    32'(e.wreg));
          chk("sb_ctrl",  32'(bus.CtrlM),        32'(e.ctrl));
        end
      end
      if (FlushM) begin
        sb.delete();
        model_occ = 0;
      end else begin
        if (acc_m) begin
          e.ctrl  = bus.CtrlE;
          e.wreg  = bus.WriteRegE;
          e.wdata = bus.WriteDataE;
          e.alu   = bus.ALUOutE;
          sb.push_back(e);
        end
        model_occ = model_occ + (acc_m ? 1 : 0) - (dep_m ? 1 : 0);
      end
    end
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] c101;
    logic [CW-1:0] cmtr;
    logic          r;

    c101 = '0;
    c101[CTRL_REGWRITE] = 1'b1;
    c101[CTRL_MEMWRITE] = 1'b1;
    cmtr = '0;
    cmtr[CTRL_MEMTORG] = 1'b1;

    Reset  = 1'b0;
    FlushM = 1'b0;
    drive(0, '0, '0, '0, '0, 0);
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_in_ready",  32'(bus.in_ready),  32'(1));
    chk("rst_occ",       32'(bus.occupancy), 32'(0));
    chk("rst_ctrl",      32'(bus.CtrlM),     32'(0));
    chk("rst_reg",       32'(bus.WriteRegM), 32'(0));
    chk("rst_wdata",     bus.WriteDataM,     32'(0));
    chk("rst_alu",       bus.ALUOutM,        32'(0));
    @(negedge CLK);
    Reset = 1'b1;
    step(1);

    // Streaming at full throughput.
    for (int i = 0; i < 4; i++) begin
      drive(1, cmtr, RW'(i + 1), DW'(i), DW'((i + 1) * 16), 1);
      step(1);
      chk("stream_alu", bus.ALUOutM, DW'((i + 1) * 16));
      chk("stream_occ", 32'(bus.occupancy), 32'(1));
    end
    drive(0, '0, '0, '0, '0, 1);
    step(2);

    // Skid fill under back-pressure, then drain in order.
    drive(1, '0, RW'(1), '0, 32'h10, 0);
    step(1);
    chk("skid_occ1", 32'(bus.occupancy), 32'(1));
    drive(1, '0, RW'(2), '0, 32'h20, 0);
    step(1);
    chk("skid_occ2",   32'(bus.occupancy), 32'(2));
    chk("skid_rdy0",   32'(bus.in_ready),  32'(0));
    chk("skid_head",   bus.ALUOutM,        32'h10);
    drive(1, '0, RW'(3), '0, 32'h30, 0);
    step(2);
    chk("skid_hold",   bus.ALUOutM,        32'h10);
    drive(1, '0, RW'(3), '0, 32'h30, 1);
    step(1);
    chk("skid_drain1", bus.ALUOutM,        32'h20);
    step(1);
    chk("skid_drain2", bus.ALUOutM,        32'h30);
    drive(0, '0, '0, '0, '0, 1);
    step(1);
    chk("skid_empty",  32'(bus.out_valid), 32'(0));

    // Flush while FULL; the same-cycle input is discarded.
    drive(1, c101, RW'(4), '0, 32'hA1, 0);
    step(1);
    drive(1, c101, RW'(5), '0, 32'hA2, 0);
    step(1);
    chk("fl_full", 32'(bus.occupancy), 32'(2));
    FlushM = 1'b1;
    drive(1, c101, RW'(6), '0, 32'h99, 0);
    step(1);
    FlushM = 1'b0;
    chk("fl_valid", 32'(bus.out_valid), 32'(0));
    chk("fl_ctrl",  32'(bus.CtrlM),     32'(0));
    chk("fl_occ",   32'(bus.occupancy), 32'(0));
    drive(0, '0, '0, '0, '0, 1);
    step(3);

    // Flush in ONE while MEM consumes the head in the same cycle.
    drive(1, c101, RW'(8), '0, 32'hB1, 1);
    step(1);
    FlushM = 1'b1;
    drive(1, c101, RW'(9), '0, 32'hB2, 1);
    step(1);
    FlushM = 1'b0;
    chk("fl2_occ", 32'(bus.occupancy), 32'(0));
    drive(0, '0, '0, '0, '0, 1);
    step(2);

    // Payload stability during a 5-cycle stall.
    drive(1, 3'b001, RW'(7), 32'hDEADBEEF, 32'h44, 0);
    step(1);
    drive(0, '0, '0, '0, '0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_reg",   32'(bus.WriteRegM), 32'(7));
      chk("stall_wdata", bus.WriteDataM,     32'hDEADBEEF);
      chk("stall_alu",   bus.ALUOutM,        32'h44);
      chk("stall_valid", 32'(bus.out_valid), 32'(1));
      step(1);
    end
    drive(0, '0, '0, '0, '0, 1);
    step(2);

    // Asynchronous reset between edges while FULL.
    drive(1, c101, RW'(9), 32'h55, 32'hC1, 0);
    step(1);
    drive(1, c101, RW'(10), 32'h66, 32'hC2, 0);
    step(1);
    #2;
    Reset = 1'b0;
    #1;
    chk("ar_valid", 32'(bus.out_valid), 32'(0));
    chk("ar_ready", 32'(bus.in_ready),  32'(1));
    chk("ar_occ",   32'(bus.occupancy), 32'(0));
    chk("ar_ctrl",  32'(bus.CtrlM),     32'(0));
    chk("ar_reg",   32'(bus.WriteRegM), 32'(0));
    chk("ar_wdata", bus.WriteDataM,     32'(0));
    chk("ar_alu",   bus.ALUOutM,        32'(0));
    drive(0, '0, '0, '0, '0, 1);
    @(posedge CLK);
    #1;
    Reset = 1'b1;
    step(1);

    // Random traffic; in_ready must not react to a same-cycle out_ready change.
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 1)), CW'($urandom), RW'($urandom), $urandom, $urandom,
            1'($urandom_range(0, 1)));
      FlushM = ($urandom_range(0, 31) == 0);
      r = bus.in_ready;
      bus.out_ready = ~bus.out_ready;
      #1;
      chk("in_ready_indep", 32'(bus.in_ready), 32'(r));
      bus.out_ready = ~bus.out_ready;
      step(1);
    end
    FlushM = 1'b0;
    drive(0, '0, '0, '0, '0, 1);
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
